neuron_core: RTL and testbench

- Clocked threshold neuron (perceptron-style firing unit) used as the basic cell of layered spiking/threshold networks.
- Each cycle it sums the unsigned weights of all active binary synapses and compares the sum against an unsigned threshold.
- It registers a one-bit axon (fire) output plus the membrane potential (the sum).
- Instances are chained: one layer's axons drive the next layer's synapses.

---
 rtl/neuron_core.sv | 53 +++++
 tb/tb_neuron_core.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/neuron_core.sv
// neuron_core: clocked threshold neuron; sums weights of active synapses and
// fires when the sum reaches the threshold.
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset, clears axon/potential
//   en        update enable; outputs hold while low
//   synapses  N binary synapse inputs; bit i selects weight i
//   weights   N packed W-bit unsigned weights, weight 0 in the LSBs
//   threshold W-bit unsigned firing threshold
//   axon      registered fire flag (sum >= threshold)
//   potential registered weighted sum, W+clog2(N) bits
module neuron_core #(
    parameter int N = 4,
    parameter int W = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic [N-1:0]               synapses,
    input  logic [N*W-1:0]             weights,
    input  logic [W-1:0]               threshold,
    output logic                       axon,
    output logic [W+$clog2(N)-1:0]     potential
);

    localparam int SW = W + $clog2(N);

    logic [SW-1:0] sum;
    logic          fire;

    // Every weight is zero-extended to SW, so N terms can never overflow.
    always_comb begin
        sum = '0;
        for (int i = 0; i < N; i++) begin
            if (synapses[i]) begin
                sum = sum + SW'(weights[i*W +: W]);
            end
        end
    end

    assign fire = (sum >= SW'(threshold));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            axon      <= 1'b0;
            potential <= '0;
        end else if (en) begin
            axon      <= fire;
            potential <= sum;
        end
    end

endmodule

// File: tb/tb_neuron_core.sv
// tb_neuron_core: scoreboard bench for neuron_core (N=4 and N=1 instances).
// Expected results are queued when stimulus is driven, compared after the edge.
module tb_neuron_core;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic [3:0]   synapses;
    logic [127:0] weights;
    logic [31:0]  threshold;
    logic         axon;
    logic [33:0]  potential;

    logic         s1;
    logic [31:0]  w1;
    logic [31:0]  th1;
    logic         axon1;
    logic [31:0]  pot1;

    typedef struct {
        logic [63:0] pot;
        logic        ax;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    neuron_core #(.N(4), .W(32)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .synapses(synapses), .weights(weights),
        .threshold(threshold),
        .axon(axon), .potential(potential)
    );

    neuron_core #(.N(1), .W(32)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en),
        .synapses(s1), .weights(w1),
        .threshold(th1),
        .axon(axon1), .potential(pot1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Entered and left at a falling edge.
    task automatic step(input string tag, input logic [3:0] s,
                        input logic e, input logic [63:0] ep,
                        input logic ea);
        exp_t x;
        exp_t y;
        synapses = s;
        en       = e;
        x.pot    = ep;
        x.ax     = ea;
        q.push_back(x);
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            check({tag, "_queue"}, 64'd0, 64'd1);
        end else begin
            y = q.pop_front();
            check({tag, "_pot"}, 64'(potential), y.pot);
            check({tag, "_axon"}, 64'(axon), 64'(y.ax));
        end
        @(negedge clk);
    endtask

    logic [3:0] r;

    initial begin
        rst_n     = 1'b0;
        en        = 1'b1;
        synapses  = 4'b1111;
        weights   = {32'd8, 32'd4, 32'd2, 32'd1};
        threshold = 32'd2;
        s1        = 1'b0;
        w1        = 32'd0;
        th1       = 32'd0;
        #1;
        check("rst_async_pot", 64'(potential), 64'd0);
        check("rst_async_axon", 64'(axon), 64'd0);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("rst_hold_pot", 64'(potential), 64'd0);
            check("rst_hold_axon", 64'(axon), 64'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step("release", 4'b1111, 1'b1, 64'd15, 1'b1);

        step("sw0", 4'b0000, 1'b1, 64'd0, 1'b0);
        step("sw1", 4'b0001, 1'b1, 64'd1, 1'b0);
        step("sw2_eq", 4'b0010, 1'b1, 64'd2, 1'b1);
        step("sw3", 4'b0011, 1'b1, 64'd3, 1'b1);
        step("sw4", 4'b0100, 1'b1, 64'd4, 1'b1);
        step("sw5", 4'b0101, 1'b1, 64'd5, 1'b1);

        step("hold1", 4'b0000, 1'b0, 64'd5, 1'b1);
        step("hold2", 4'b0000, 1'b0, 64'd5, 1'b1);
        step("hold3", 4'b0000, 1'b0, 64'd5, 1'b1);
        step("resume", 4'b0000, 1'b1, 64'd0, 1'b0);

        // Binary weights make the sum equal the synapse pattern.
        for (int i = 0; i < 20; i++) begin
            r = 4'($urandom_range(0, 15));
            step("rand", r, 1'b1, 64'(r), r >= 4'd2);
        end

        step("pre_rst", 4'b0011, 1'b1, 64'd3, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_pot", 64'(potential), 64'd0);
        check("mid_rst_axon", 64'(axon), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst", 4'b0001, 1'b1, 64'd1, 1'b0);

        weights   = {4{32'hFFFF_FFFF}};
        threshold = 32'hFFFF_FFFF;
        step("max_sum", 4'b1111, 1'b1, 64'h3_FFFF_FFFC, 1'b1);
        step("max_eq", 4'b0001, 1'b1, 64'hFFFF_FFFF, 1'b1);
        step("max_zero", 4'b0000, 1'b1, 64'd0, 1'b0);
        threshold = 32'd0;
        step("thr0", 4'b0000, 1'b1, 64'd0, 1'b1);

        s1  = 1'b1;
        w1  = 32'd7;
        th1 = 32'd8;
        @(posedge clk);
        #1;
        check("n1_pot", 64'(pot1), 64'd7);
        check("n1_axon", 64'(axon1), 64'd0);
        @(negedge clk);
        th1 = 32'd7;
        @(posedge clk);
        #1;
        check("n1_eq_axon", 64'(axon1), 64'd1);
        @(negedge clk);
        s1 = 1'b0;
        @(posedge clk);
        #1;
        check("n1_off_pot", 64'(pot1), 64'd0);
        check("n1_off_axon", 64'(axon1), 64'd0);

        if (q.size() != 0) begin
            check("queue_empty", 64'(q.size()), 64'd0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
